bin2bcd_seq: RTL and testbench

- Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
- Sits directly downstream of the 3x3 shift-add multiplier.
- Takes the multiplier's product and done pulse and converts the product to decimal digits for the seven-segment display driver.
- Uses the same start/done handshake style as the multiplier, so the multiplier's done feeds this block's start directly.

---
 rtl/bin2bcd_pkg.sv | 26 ++
 rtl/bin2bcd_seq_if.sv | 27 ++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bin2bcd_seq.sv | 132 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg
//   Shared constants for the sequential binary-to-BCD converter:
//   - FSM state encodings (IDLE / SHIFT / DONE)
//   - BCD digit width and the add-3 threshold
//   - pow10(), used by the elaboration-time size check
//   Optional feature macro used by the block: BCD_BLANK_EN.
package bin2bcd_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam int         BCD_DIGIT_W   = 4;
   localparam logic [3:0] ADJ_THRESHOLD = 4'd5;

   // 10**n as a 64-bit value. Keeps the range check free of 32-bit overflow.
   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int k = 0; k < n; k++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if
//   start/done handshake bundle between a producer (the multiplier) and the
//   binary-to-BCD converter.
//   master : drives start, bin_in; observes busy, done, bcd_out (, blank)
//   slave  : the converter side
//   Optional feature macro: BCD_BLANK_EN adds the blank mask signal.
interface bin2bcd_seq_if
   import bin2bcd_pkg::*;
#(
   parameter int BIN_WIDTH = 6,
   parameter int DIGITS    = 2
);
   logic                          start;
   logic [BIN_WIDTH-1:0]          bin_in;
   logic                          busy;
   logic                          done;
   logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0]             blank;

   modport master (output start, bin_in, input busy, done, bcd_out, blank);
   modport slave  (input start, bin_in, output busy, done, bcd_out, blank);
`else
   modport master (output start, bin_in, input busy, done, bcd_out);
   modport slave  (input start, bin_in, output busy, done, bcd_out);
`endif
endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj
//   Combinational double-dabble correction for one BCD digit: adds 3 when
//   the digit is >= 5 so that the following left shift carries correctly
//   into the next decimal digit.
//   Ports: digit_in (4) -> digit_out (4)
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_in,
   output logic [BCD_DIGIT_W-1:0] digit_out
);

   // Inputs >= 5 only ever reach 9 before adjustment, so 4 bits never wrap.
   assign digit_out = (digit_in >= ADJ_THRESHOLD) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential shift-and-add-3 binary-to-BCD converter. A one-cycle start
//   samples bin_in; BIN_WIDTH shift cycles later bcd_out is updated and done
//   pulses for one cycle. start while busy or in DONE is ignored.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    bin2bcd_seq_if.slave: start, bin_in, busy, done, bcd_out
//            (+ blank leading-zero mask when BCD_BLANK_EN is defined)
//   Optional feature macro: BCD_BLANK_EN.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_WIDTH = 6,
   parameter int DIGITS    = 2
)(
   input  logic          clk,
   input  logic          reset,
   bin2bcd_seq_if.slave  bus
);

   localparam int SCR_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   // The scratch register must be able to hold the largest input value.
   if (pow10(DIGITS) <= ((64'd1 << BIN_WIDTH) - 64'd1)) begin : g_size_check
      $error("bin2bcd_seq: DIGITS=%0d too small for BIN_WIDTH=%0d", DIGITS, BIN_WIDTH);
   end

   logic [1:0]           state_reg;
   logic [CNT_W-1:0]     count_reg;
   logic [BIN_WIDTH-1:0] bin_reg;
   logic [SCR_W-1:0]     scratch_reg;
   logic [SCR_W-1:0]     bcd_reg;
   logic                 busy_reg;
   logic                 done_reg;

   logic [SCR_W-1:0]     adjusted;
   logic [SCR_W-1:0]     scratch_next;
   logic [BIN_WIDTH-1:0] bin_next;
   logic                 unused_top_bit;

   // Per-digit add-3 ahead of each shift.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_in  (scratch_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_out (adjusted[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // {scratch, bin} << 1; the bit leaving the top of scratch is always zero
   // given the DIGITS/BIN_WIDTH constraint.
   assign {unused_top_bit, scratch_next, bin_next} = {adjusted, bin_reg, 1'b0};

`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] blank_reg;
   logic [DIGITS-1:0] blank_next;
   logic              nonzero_above;

   // Digit i is blanked when it and every higher digit are zero; digit 0 is
   // never blanked so a zero result still shows one "0".
   always_comb begin
      blank_next    = '0;
      nonzero_above = 1'b0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         nonzero_above = nonzero_above |
                         (scratch_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0);
         blank_next[i] = ~nonzero_above;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blank_reg <= ~(DIGITS'(1));
      end else if (state_reg == SHIFT && count_reg == CNT_W'(1)) begin
         blank_reg <= blank_next;
      end
   end

   assign bus.blank = blank_reg;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         count_reg   <= '0;
         bin_reg     <= '0;
         scratch_reg <= '0;
         bcd_reg     <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  bin_reg     <= bus.bin_in;
                  scratch_reg <= '0;
                  count_reg   <= CNT_W'(BIN_WIDTH);
                  busy_reg    <= 1'b1;
                  state_reg   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch_reg <= scratch_next;
               bin_reg     <= bin_next;
               count_reg   <= count_reg - CNT_W'(1);
               // Last shift: publish the shifted result as we enter DONE.
               if (count_reg == CNT_W'(1)) begin
                  bcd_reg   <= scratch_next;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;
   assign bus.bcd_out = bcd_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
//   Self-checking bench for bin2bcd_seq (default parameters). Table-driven
//   conversions plus hand-written sequences for ignored starts, reset
//   mid-conversion, back-to-back starts and a modelled multiplier chain.
//   Optional feature macro: BCD_BLANK_EN enables blank-mask checks.
module tb_bin2bcd_seq;
   import bin2bcd_pkg::*;

   logic clk;
   logic reset;
   int   checks_total;
   int   checks_passed;

   bin2bcd_seq_if #(.BIN_WIDTH(6), .DIGITS(2)) bus ();

   bin2bcd_seq #(.BIN_WIDTH(6), .DIGITS(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] bin;
      logic [7:0] bcd;
      logic [1:0] blank;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks_total++;
      if (act === req) begin
         checks_passed++;
      end else begin
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   // Start one conversion and follow it to its done pulse.
   task automatic convert(input logic [5:0] v, input logic [7:0] eb,
                          input logic [1:0] ebl, input string nm);
      int lat;
      lat = 0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bin_in = v;
      @(posedge clk); #1;
      check({nm, " busy@E0"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      bus.start  = 1'b0;
      bus.bin_in = ~v;                 // must not disturb the conversion
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (bus.done) break;
      end
      check({nm, " latency"}, 32'(lat), 32'd6);
      check({nm, " bcd"}, 32'(bus.bcd_out), 32'(eb));
      check({nm, " busy@done"}, 32'(bus.busy), 32'd0);
`ifdef BCD_BLANK_EN
      check({nm, " blank"}, 32'(bus.blank), 32'(ebl));
`else
      if (ebl === 2'bxx) $display("unreachable");
`endif
      @(posedge clk); #1;
      check({nm, " done_1cyc"}, 32'(bus.done), 32'd0);
      $display("conv %s: bin=%0d bcd=%h latency=%0d", nm, v, bus.bcd_out, lat);
   endtask

   // Count done pulses over n cycles.
   task automatic count_dones(input int n, output int cnt);
      cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         if (bus.done) cnt++;
      end
   endtask

   initial begin
      int cnt;
      int lat;
      checks_total  = 0;
      checks_passed = 0;

      vecs[0] = '{6'd35, 8'h35, 2'b00};
      vecs[1] = '{6'd0,  8'h00, 2'b10};
      vecs[2] = '{6'd63, 8'h63, 2'b00};
      vecs[3] = '{6'd4,  8'h04, 2'b10};
      vecs[4] = '{6'd9,  8'h09, 2'b10};
      vecs[5] = '{6'd10, 8'h10, 2'b00};
      vecs[6] = '{6'd28, 8'h28, 2'b00};
      vecs[7] = '{6'd49, 8'h49, 2'b00};

      bus.start  = 1'b0;
      bus.bin_in = '0;
      reset      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst done", 32'(bus.done), 32'd0);
      check("rst bcd", 32'(bus.bcd_out), 32'd0);
`ifdef BCD_BLANK_EN
      check("rst blank", 32'(bus.blank), 32'b10);
`endif
      $display("reset: busy=%0d done=%0d bcd=%h", bus.busy, bus.done, bus.bcd_out);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven conversions.
      for (int i = 0; i < 8; i++) begin
         convert(vecs[i].bin, vecs[i].bcd, vecs[i].blank, $sformatf("vec%0d", i));
      end

      // Second start during a conversion is ignored: one done, result 28.
      @(negedge clk);
      bus.start = 1'b1; bus.bin_in = 6'd28;
      @(negedge clk);                  // E0 passed
      bus.start = 1'b0;
      @(negedge clk);                  // E1 passed
      bus.start = 1'b1; bus.bin_in = 6'd49;   // sampled at E2
      @(negedge clk);
      bus.start = 1'b0;
      count_dones(12, cnt);
      check("ignore_start dones", 32'(cnt), 32'd1);
      check("ignore_start bcd", 32'(bus.bcd_out), 32'h28);
      check("ignore_start busy", 32'(bus.busy), 32'd0);
      $display("ignore_start: dones=%0d bcd=%h", cnt, bus.bcd_out);
      convert(6'd49, 8'h49, 2'b00, "fresh49");

      // Start presented while in DONE is ignored.
      @(negedge clk);
      bus.start = 1'b1; bus.bin_in = 6'd12;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (bus.done) break;
      end
      check("pre_done latency", 32'(lat), 32'd6);
      @(negedge clk);
      bus.start = 1'b1; bus.bin_in = 6'd63;   // sampled in DONE
      @(posedge clk); #1;
      check("start_in_done busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      bus.start = 1'b0;
      count_dones(10, cnt);
      check("start_in_done dones", 32'(cnt), 32'd0);
      check("start_in_done bcd", 32'(bus.bcd_out), 32'h12);
      $display("start_in_done: dones=%0d bcd=%h", cnt, bus.bcd_out);

      // Back-to-back: start in the first IDLE cycle after DONE is accepted.
      @(negedge clk);
      bus.start = 1'b1; bus.bin_in = 6'd21;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (bus.done) break;
      end
      @(negedge clk);                  // in DONE
      @(negedge clk);                  // now IDLE
      bus.start = 1'b1; bus.bin_in = 6'd57;
      @(posedge clk); #1;
      check("b2b busy", 32'(bus.busy), 32'd1);
      check("b2b prev bcd", 32'(bus.bcd_out), 32'h21);
      @(negedge clk);
      bus.start = 1'b0;
      count_dones(8, cnt);
      check("b2b dones", 32'(cnt), 32'd1);
      check("b2b bcd", 32'(bus.bcd_out), 32'h57);
      $display("back_to_back: dones=%0d bcd=%h", cnt, bus.bcd_out);

      // Reset mid-conversion clears everything without a clock edge.
      @(negedge clk);
      bus.start = 1'b1; bus.bin_in = 6'd33;
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk); @(posedge clk);  // E1, E2
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midrst busy", 32'(bus.busy), 32'd0);
      check("midrst done", 32'(bus.done), 32'd0);
      check("midrst bcd", 32'(bus.bcd_out), 32'd0);
      $display("mid_reset: busy=%0d done=%0d bcd=%h", bus.busy, bus.done, bus.bcd_out);
      @(negedge clk);
      reset = 1'b0;
      count_dones(10, cnt);
      check("midrst no_done", 32'(cnt), 32'd0);
      convert(6'd35, 8'h35, 2'b00, "after_rst");

      // Multiplier chain: product = a*b fed straight into start/bin_in.
      convert(6'(3'd7 * 3'd4), 8'h28, 2'b00, "mult7x4");
      convert(6'(3'd4 * 3'd1), 8'h04, 2'b10, "mult4x1");
      convert(6'(3'd7 * 3'd7), 8'h49, 2'b00, "mult7x7");

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
